// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and the round-robin helper for the completion-bus arbiter.
package cdb_arbiter_pkg;

   localparam int ROB_SZ_LOG = 3;
   localparam int CDB_TAG_W  = ROB_SZ_LOG + 1;

   localparam logic [1:0] CDB_ALU = 2'd0;
   localparam logic [1:0] CDB_LAD = 2'd1;
   localparam logic [1:0] CDB_STR = 2'd2;

   // One-hot grant {str, lad, alu}: first requester after last in ALU->LAD->STR order.
   function automatic logic [2:0] rr_grant(input logic [1:0] last, input logic [2:0] req);
      logic [2:0] g;
      g = 3'b000;
      case (last)
         CDB_ALU: begin
            if (req[1])      g = 3'b010;
            else if (req[2]) g = 3'b100;
            else if (req[0]) g = 3'b001;
         end
         CDB_LAD: begin
            if (req[2])      g = 3'b100;
            else if (req[0]) g = 3'b001;
            else if (req[1]) g = 3'b010;
         end
         default: begin
            if (req[0])      g = 3'b001;
            else if (req[1]) g = 3'b010;
            else if (req[2]) g = 3'b100;
         end
      endcase
      return g;
   endfunction

   function automatic logic [1:0] grant_src(input logic [2:0] g);
      logic [1:0] s;
      s = CDB_ALU;
      if (g[1])      s = CDB_LAD;
      else if (g[2]) s = CDB_STR;
      return s;
   endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-source completion FIFO; head is read combinationally so a grant can
// register it onto the CDB in the same cycle it is popped.
module cdb_arbiter_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    flush,
   input  logic                    push,
   input  logic                    pop,
   input  logic [W-1:0]            din,
   output logic [W-1:0]            head,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          active;
   logic          read_en;
   logic          write_en;

   assign full   = (count_reg == FULL_CNT);
   assign active = !rst && rdy && !flush;
   assign read_en  = active && pop && (count_reg != '0);
   // A push into a full FIFO is only kept when the head leaves on the same edge.
   assign write_en = active && push && (!full || read_en);

   always_ff @(posedge clk) begin
      if (write_en) mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (rdy) begin
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (write_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (read_en)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({write_en, read_en})
               2'b10:   count_reg <= count_reg + (AW+1)'(1);
               2'b01:   count_reg <= count_reg - (AW+1)'(1);
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that drains three completion FIFOs onto one registered
// common data bus feeding the ROB update port and RS wakeup.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = CDB_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             flush,
   input  logic             alu_valid,
   input  logic [TAG_W-1:0] alu_tag,
   input  logic [31:0]      alu_res,
   input  logic [31:0]      alu_res2,
   input  logic             lad_valid,
   input  logic [TAG_W-1:0] lad_tag,
   input  logic [31:0]      lad_res,
   input  logic             str_valid,
   input  logic [TAG_W-1:0] str_tag,
   output logic             alu_full,
   output logic             lad_full,
   output logic             str_full,
   output logic             cdb_valid,
   output logic [1:0]       cdb_src,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [31:0]      cdb_res,
   output logic [31:0]      cdb_res2
);

   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int ALU_W = TAG_W + 64;
   localparam int LAD_W = TAG_W + 32;

   logic [ALU_W-1:0] alu_head;
   logic [LAD_W-1:0] lad_head;
   logic [TAG_W-1:0] str_head;
   logic [CW-1:0]    alu_count;
   logic [CW-1:0]    lad_count;
   logic [CW-1:0]    str_count;
   logic [2:0]       req;
   logic [2:0]       grant;
   logic [1:0]       last_grant_reg;

   logic             cdb_valid_reg;
   logic [1:0]       cdb_src_reg;
   logic [TAG_W-1:0] cdb_tag_reg;
   logic [31:0]      cdb_res_reg;
   logic [31:0]      cdb_res2_reg;

   cdb_arbiter_fifo #(.DEPTH(DEPTH), .W(ALU_W)) u_alu_fifo (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .push(alu_valid), .pop(grant[0]), .din({alu_tag, alu_res, alu_res2}),
      .head(alu_head), .count(alu_count), .full(alu_full)
   );

   cdb_arbiter_fifo #(.DEPTH(DEPTH), .W(LAD_W)) u_lad_fifo (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .push(lad_valid), .pop(grant[1]), .din({lad_tag, lad_res}),
      .head(lad_head), .count(lad_count), .full(lad_full)
   );

   cdb_arbiter_fifo #(.DEPTH(DEPTH), .W(TAG_W)) u_str_fifo (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .push(str_valid), .pop(grant[2]), .din(str_tag),
      .head(str_head), .count(str_count), .full(str_full)
   );

   // Requests come from registered counts, so this cycle's pushes cannot win.
   assign req   = {str_count != '0, lad_count != '0, alu_count != '0};
   assign grant = rr_grant(last_grant_reg, req);

   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_valid_reg  <= 1'b0;
         cdb_src_reg    <= CDB_ALU;
         cdb_tag_reg    <= '0;
         cdb_res_reg    <= '0;
         cdb_res2_reg   <= '0;
         last_grant_reg <= CDB_STR;
      end else if (rdy) begin
         if (flush) begin
            cdb_valid_reg  <= 1'b0;
            last_grant_reg <= CDB_STR;
         end else if (grant != 3'b000) begin
            cdb_valid_reg  <= 1'b1;
            cdb_src_reg    <= grant_src(grant);
            last_grant_reg <= grant_src(grant);
            if (grant[0]) begin
               cdb_tag_reg  <= alu_head[ALU_W-1 -: TAG_W];
               cdb_res_reg  <= alu_head[63:32];
               cdb_res2_reg <= alu_head[31:0];
            end else if (grant[1]) begin
               cdb_tag_reg  <= lad_head[LAD_W-1 -: TAG_W];
               cdb_res_reg  <= lad_head[31:0];
               cdb_res2_reg <= '0;
            end else begin
               cdb_tag_reg  <= str_head;
               cdb_res_reg  <= '0;
               cdb_res2_reg <= '0;
            end
         end else begin
            cdb_valid_reg <= 1'b0;
         end
      end
   end

   assign cdb_valid = cdb_valid_reg;
   assign cdb_src   = cdb_src_reg;
   assign cdb_tag   = cdb_tag_reg;
   assign cdb_res   = cdb_res_reg;
   assign cdb_res2  = cdb_res2_reg;

endmodule
